// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin arbitration between two pixel requesters
// plus a full-screen clear sweep with priority. Optional clipping via FB_WRITE_ARBITER_CLIP_EN.
module fb_write_arbiter #(
   parameter int   WIDTH       = 640,
   parameter int   HEIGHT      = 480,
   parameter logic CLEAR_COLOR = 1'b0
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        a_valid,
   input  logic [10:0] a_x,
   input  logic [10:0] a_y,
   input  logic        a_color,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [10:0] b_x,
   input  logic [10:0] b_y,
   input  logic        b_color,
   output logic        b_ready,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic        clear_done,
   output logic [10:0] fb_x,
   output logic [10:0] fb_y,
   output logic        fb_color,
   output logic        fb_write
`ifdef FB_WRITE_ARBITER_CLIP_EN
   ,
   output logic [15:0] clip_count
`endif
);

   localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
   localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t      state_q;
   logic        last_b_q;
   logic [10:0] cx_q, cy_q;
   logic [10:0] fb_x_q, fb_y_q;
   logic        fb_color_q, fb_write_q;
   logic        clear_busy_q, clear_done_q;

   logic        grant_a, grant_b, accept_ok, xfer;
   logic        sweep_on, sweep_last;
   logic [10:0] sweep_x, sweep_y;
   logic [10:0] req_x, req_y;
   logic        req_color, req_clip;

   always_comb begin
      // Tie goes to whichever requester was not granted last
      grant_a    = a_valid && (!b_valid || last_b_q);
      grant_b    = b_valid && !grant_a;
      accept_ok  = reset_n && (state_q == IDLE) && !clear_start;
      a_ready    = accept_ok && grant_a;
      b_ready    = accept_ok && grant_b;
      xfer       = a_ready || b_ready;
      req_x      = grant_b ? b_x : a_x;
      req_y      = grant_b ? b_y : a_y;
      req_color  = grant_b ? b_color : a_color;
      // The start cycle already emits pixel (0,0), so the counters hold the next pixel
      sweep_on   = (state_q == CLEAR) || clear_start;
      sweep_x    = (state_q == CLEAR) ? cx_q : 11'd0;
      sweep_y    = (state_q == CLEAR) ? cy_q : 11'd0;
      sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
   end

`ifdef FB_WRITE_ARBITER_CLIP_EN
   localparam logic [10:0] X_LIM = 11'(WIDTH);
   localparam logic [10:0] Y_LIM = 11'(HEIGHT);
   logic [15:0] clip_count_q;

   assign req_clip   = (req_x >= X_LIM) || (req_y >= Y_LIM);
   assign clip_count = clip_count_q;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         clip_count_q <= 16'd0;
      end else if (!sweep_on && xfer && req_clip && (clip_count_q != 16'hFFFF)) begin
         clip_count_q <= clip_count_q + 16'd1;
      end
   end
`else
   assign req_clip = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_b_q     <= 1'b1;
         cx_q         <= 11'd0;
         cy_q         <= 11'd0;
         fb_x_q       <= 11'd0;
         fb_y_q       <= 11'd0;
         fb_color_q   <= 1'b0;
         fb_write_q   <= 1'b0;
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
      end else if (sweep_on) begin
         fb_x_q       <= sweep_x;
         fb_y_q       <= sweep_y;
         fb_color_q   <= CLEAR_COLOR;
         fb_write_q   <= 1'b1;
         clear_busy_q <= 1'b1;
         clear_done_q <= sweep_last;
         state_q      <= sweep_last ? IDLE : CLEAR;
         if (sweep_x == X_LAST) begin
            cx_q <= 11'd0;
            cy_q <= sweep_y + 11'd1;
         end else begin
            cx_q <= sweep_x + 11'd1;
            cy_q <= sweep_y;
         end
      end else begin
         clear_busy_q <= 1'b0;
         clear_done_q <= 1'b0;
         fb_write_q   <= xfer && !req_clip;
         if (xfer) begin
            fb_x_q     <= req_x;
            fb_y_q     <= req_y;
            fb_color_q <= req_color;
            last_b_q   <= grant_b;
         end
      end
   end

   assign fb_x       = fb_x_q;
   assign fb_y       = fb_y_q;
   assign fb_color   = fb_color_q;
   assign fb_write   = fb_write_q;
   assign clear_busy = clear_busy_q;
   assign clear_done = clear_done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed scoreboard bench for fb_write_arbiter on a 4x3 screen.
module tb_fb_write_arbiter;

   localparam int W = 4;
   localparam int H = 3;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        c;
      logic        d;
   } pix_t;

   logic        clk, rst_n;
   logic        a_valid, a_color, a_ready;
   logic [10:0] a_x, a_y;
   logic        b_valid, b_color, b_ready;
   logic [10:0] b_x, b_y;
   logic        clear_start, clear_busy, clear_done;
   logic [10:0] fb_x, fb_y;
   logic        fb_color, fb_write;
`ifdef FB_WRITE_ARBITER_CLIP_EN
   logic [15:0] clip_count;
`endif

   pix_t sb[$];
   pix_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   int   busy_base, done_base;
   logic last_b;

   fb_write_arbiter #(.WIDTH(W), .HEIGHT(H), .CLEAR_COLOR(1'b0)) dut (
      .CLOCK_50(clk), .reset_n(rst_n),
      .a_valid(a_valid), .a_x(a_x), .a_y(a_y), .a_color(a_color), .a_ready(a_ready),
      .b_valid(b_valid), .b_x(b_x), .b_y(b_y), .b_color(b_color), .b_ready(b_ready),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write)
`ifdef FB_WRITE_ARBITER_CLIP_EN
      , .clip_count(clip_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pix_t mk(input int x, input int y, input logic c, input logic d);
      pix_t p;
      p.x = 11'(x);
      p.y = 11'(y);
      p.c = c;
      p.d = d;
      return p;
   endfunction

   function automatic pix_t clr_px(input int i);
      return mk(i % W, i / W, 1'b0, i == W * H - 1);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Every fb write must match the oldest expected pixel
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (fb_write === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_write", {fb_x, fb_y, fb_color}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               $display("write x=%0d y=%0d c=%0d done=%0d", fb_x, fb_y, fb_color, clear_done);
               chk("fb_x", 32'(fb_x), 32'(mon_e.x));
               chk("fb_y", 32'(fb_y), 32'(mon_e.y));
               chk("fb_color", 32'(fb_color), 32'(mon_e.c));
               chk("clear_done", 32'(clear_done), 32'(mon_e.d));
            end
         end
         if (clear_busy === 1'b1) busy_cnt++;
         if (clear_done === 1'b1) done_cnt++;
      end
   end

   initial begin
      rst_n = 1'b0; clear_start = 1'b0;
      a_valid = 1'b1; a_x = 11'd1; a_y = 11'd1; a_color = 1'b1;
      b_valid = 1'b0; b_x = 11'd0; b_y = 11'd0; b_color = 1'b0;
      last_b = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_fb_write", 32'(fb_write), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd0);
      chk("rst_done", 32'(clear_done), 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd0);
      chk("rst_fb_x", 32'(fb_x), 32'd0);
      cyc();
      rst_n = 1'b1; a_valid = 1'b0;
      @(negedge clk);
      cyc();

      // Contention: both held for 4 cycles, A wins the first tie
      a_valid = 1'b1; a_x = 11'd1; a_y = 11'd0; a_color = 1'b1;
      b_valid = 1'b1; b_x = 11'd2; b_y = 11'd1; b_color = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("contend_a_ready", 32'(a_ready), 32'(last_b));
         chk("contend_b_ready", 32'(b_ready), 32'(!last_b));
         if (i > 0) chk("contend_nogap", 32'(fb_write), 32'd1);
         if (last_b) sb.push_back(mk(1, 0, 1'b1, 1'b0));
         else        sb.push_back(mk(2, 1, 1'b0, 1'b0));
         last_b = !last_b;
         cyc();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      cyc();

      // Single requester A
      a_valid = 1'b1; a_x = 11'd3; a_y = 11'd2; a_color = 1'b1;
      @(negedge clk);
      chk("single_a_ready", 32'(a_ready), 32'd1);
      chk("single_b_ready", 32'(b_ready), 32'd0);
      sb.push_back(mk(3, 2, 1'b1, 1'b0));
      last_b = 1'b0;
      cyc();
      a_valid = 1'b0;
      @(negedge clk);
      chk("single_write", 32'(fb_write), 32'd1);
      cyc();
      @(negedge clk);
      chk("single_idle_write", 32'(fb_write), 32'd0);
      cyc();

      // Clear colliding with A, re-pulse at pixel 5, A accepted on the final pixel
      a_valid = 1'b1; a_x = 11'd2; a_y = 11'd2; a_color = 1'b1;
      clear_start = 1'b1;
      busy_base = busy_cnt; done_base = done_cnt;
      @(negedge clk);
      chk("collide_a_ready", 32'(a_ready), 32'd0);
      sb.push_back(clr_px(0));
      cyc();
      for (int k = 1; k <= W * H; k++) begin
         clear_start = (k == 5);
         @(negedge clk);
         chk("clear_busy", 32'(clear_busy), 32'd1);
         chk("clear_a_ready", 32'(a_ready), 32'(k == W * H));
         if (k < W * H) begin
            sb.push_back(clr_px(k));
         end else begin
            sb.push_back(mk(2, 2, 1'b1, 1'b0));
            last_b = 1'b0;
         end
         cyc();
      end
      a_valid = 1'b0; clear_start = 1'b0;
      @(negedge clk);
      chk("clear_busy_end", 32'(clear_busy), 32'd0);
      chk("clear_busy_cycles", 32'(busy_cnt - busy_base), 32'(W * H));
      chk("clear_done_count", 32'(done_cnt - done_base), 32'd1);
      cyc();
      @(negedge clk);
      chk("clear_drained", 32'(sb.size()), 32'd0);
      cyc();

      // Reset dropped mid-sweep
      clear_start = 1'b1;
      done_base = done_cnt;
      @(negedge clk);
      sb.push_back(clr_px(0));
      cyc();
      clear_start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("abort_busy", 32'(clear_busy), 32'd1);
         sb.push_back(clr_px(k));
         cyc();
      end
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_fb_write", 32'(fb_write), 32'd0);
      chk("abort_busy_low", 32'(clear_busy), 32'd0);
      chk("abort_done_low", 32'(clear_done), 32'd0);
      sb.delete();
      last_b = 1'b1;
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_abort_write", 32'(fb_write), 32'd0);
         chk("post_abort_busy", 32'(clear_busy), 32'd0);
         cyc();
      end
      chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);

      // Tie right after reset goes to A again
      a_valid = 1'b1; a_x = 11'd0; a_y = 11'd1; a_color = 1'b0;
      b_valid = 1'b1; b_x = 11'd3; b_y = 11'd0; b_color = 1'b1;
      @(negedge clk);
      chk("tie_a_ready", 32'(a_ready), 32'd1);
      chk("tie_b_ready", 32'(b_ready), 32'd0);
      sb.push_back(mk(0, 1, 1'b0, 1'b0));
      last_b = 1'b0;
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      cyc();

`ifdef FB_WRITE_ARBITER_CLIP_EN
      a_valid = 1'b1; a_x = 11'(W); a_y = 11'd1; a_color = 1'b1;
      @(negedge clk);
      chk("clip_a_ready", 32'(a_ready), 32'd1);
      cyc();
      a_x = 11'(W - 1); a_y = 11'(H - 1); a_color = 1'b0;
      @(negedge clk);
      chk("clip_no_write", 32'(fb_write), 32'd0);
      chk("clip_count_1", 32'(clip_count), 32'd1);
      chk("clip_a_ready2", 32'(a_ready), 32'd1);
      sb.push_back(mk(W - 1, H - 1, 1'b0, 1'b0));
      cyc();
      a_valid = 1'b0;
      @(negedge clk);
      chk("clip_write", 32'(fb_write), 32'd1);
      chk("clip_count_hold", 32'(clip_count), 32'd1);
      cyc();
`endif

      @(negedge clk);
      chk("final_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sole owner of the VGA framebuffer pixel write port: x[10:0], y[10:0], pixel_color, pixel_write.
- Shares that port between two pixel requesters, A and B (e.g. ps2 cursor plotter and line drawer), using round-robin arbitration.
- Contains a built-in screen-clear sequencer that sweeps every pixel. The sequencer has priority over both requesters.
- Sits between the drawing logic and the framebuffer in the DE1_SoC top level.

Parameters:
- WIDTH, 640, horizontal resolution; clear sweeps x = 0..WIDTH-1
- HEIGHT, 480, vertical resolution; clear sweeps y = 0..HEIGHT-1
- CLEAR_COLOR, 1'b0, pixel_color written during a clear

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a pixel
- a_x  in  11  requester A x coordinate
- a_y  in  11  requester A y coordinate
- a_color  in  1  requester A pixel colour
- a_ready  out  1  A's pixel accepted this cycle (combinational)
- b_valid, b_x, b_y, b_color, b_ready  same as A, for requester B
- clear_start  in  1  single-cycle pulse: begin a full-screen clear
- clear_busy  out  1  high while the clear sweep runs
- clear_done  out  1  one-cycle pulse on the final clear pixel
- fb_x  out  11  to framebuffer x
- fb_y  out  11  to framebuffer y
- fb_color  out  1  to framebuffer pixel_color
- fb_write  out  1  to framebuffer pixel_write

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE
  - all fb_* = 0, clear_busy = 0, clear_done = 0
  - a_ready = b_ready = 0 while reset_n is low
  - last_grant = B, so A wins the first tie
- Handshake: a transfer occurs when valid && ready in the same cycle. Requesters hold x, y and color stable until ready.
- IDLE state:
  - ready goes only to the granted requester, and only when state = IDLE and clear_start = 0.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the one not in last_grant is granted. last_grant updates on every transfer.
- Latency: the fb_* outputs are registered. A transfer in cycle N gives fb_write = 1 with that pixel in cycle N+1. fb_write = 0 in any cycle after a non-transfer cycle.
- clear_start sampled high in IDLE:
  - Go to CLEAR. No request is accepted that cycle, even if valid.
  - Load the sweep counters cx = 0, cy = 0.
- CLEAR state:
  - Every cycle the registered outputs are fb_x = cx, fb_y = cy, fb_color = CLEAR_COLOR, fb_write = 1.
  - cx increments each cycle. At cx = WIDTH-1, cx wraps to 0 and cy increments.
  - The first clear pixel appears the cycle after clear_start is sampled. The sweep is exactly WIDTH*HEIGHT consecutive write cycles.
  - clear_busy = 1 from the cycle after clear_start through the final pixel cycle.
  - clear_done = 1 only in the cycle fb_write carries (WIDTH-1, HEIGHT-1).
  - State returns to IDLE after the final pixel, so requests can be accepted in the cycle that pixel is output.
  - a_ready = b_ready = 0 throughout CLEAR.
  - clear_start during CLEAR is ignored: the sweep does not restart.
- Reset mid-clear: the sweep aborts immediately. All outputs return to reset values and no clear_done is produced.
- Widths: cx and cy are 11 bits. Requester coordinates pass through unmodified unless the optional feature below is compiled in.
- The block has no internal queue; back-pressure is applied only through ready.

Optional Feature:
- Macro: FB_WRITE_ARBITER_CLIP_EN
- Defined:
  - A transferred pixel with x >= WIDTH or y >= HEIGHT is still accepted (ready asserted as normal) and still updates last_grant.
  - It produces fb_write = 0 in the following cycle.
  - A 16-bit saturating output clip_count (extra port, reset 0) increments once per clipped pixel.
- Undefined: coordinates pass through unchecked, and neither the clip_count port nor its logic exists.

Test Plan:
- Reset then single requester: A valid at (5, 7, color 1), B idle → a_ready = 1 that cycle; next cycle fb_x = 5, fb_y = 7, fb_color = 1, fb_write = 1; following cycle fb_write = 0.
- Contention: A and B both valid and held for 4 cycles → grants A, B, A, B; fb outputs show A, B, A, B pixels on consecutive cycles with no gaps.
- Clear with WIDTH = 4, HEIGHT = 3:
  - pulse clear_start → 12 consecutive fb_write cycles in order (0,0), (1,0), (2,0), (3,0), (0,1) … (3,2), all with color 0.
  - clear_done high only with (3,2); clear_busy high for exactly 12 cycles.
- Collision: clear_start in the same cycle as A valid → a_ready = 0. A is held through the sweep and is accepted in the cycle (3,2) is output. A's pixel appears on fb the next cycle.
- Mid-clear events:
  - clear_start re-pulsed at sweep pixel 5 → sweep continues unchanged, 12 writes total.
  - Separate run: reset_n dropped at pixel 5 → fb_write = 0 and clear_busy = 0 immediately; no clear_done.
- With FB_WRITE_ARBITER_CLIP_EN: A sends (640, 10) → a_ready = 1, no fb_write, clip_count = 1. A then sends (639, 479) → fb_write = 1, clip_count stays 1.
